// File: rtl/toom4_serial_clmul.sv
// Bit-serial carry-less (GF(2)[x]) multiplier: operands are split into four limbs and the
// 16 limb products are built one bit per cycle into seven diagonal accumulators.
// Optional early termination on the highest set limb bit: define TOOM4_CLMUL_EARLY_TERM_EN.
module toom4_serial_clmul #(
  parameter int N = 409
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int W  = (N + 3) / 4;
  localparam int AW = 2 * W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMBINE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    al_q  [4];
  logic [W-1:0]    al_d  [4];
  logic [AW-1:0]   bl_q  [4];
  logic [AW-1:0]   bl_d  [4];
  logic [AW-1:0]   acc_q [7];
  logic [AW-1:0]   acc_d [7];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*N-1:0]  c_q, c_d;
  logic [2*N-1:0]  comb_s;
  logic [4*W-1:0]  a_pad_s, b_pad_s;
  logic            last_s;

  // Zero-pad the operands to four full limbs.
  always_comb begin
    a_pad_s = '0;
    b_pad_s = '0;
    a_pad_s[N-1:0] = a;
    b_pad_s[N-1:0] = b;
  end

`ifdef TOOM4_CLMUL_EARLY_TERM_EN
  logic [W-1:0]  a_or_s;
  logic [CW-1:0] a_msb_s;
  logic [CW-1:0] last_idx_q;

  // Highest bit index set in any a-limb; RUN can stop once that index is processed.
  always_comb begin
    a_or_s  = '0;
    a_msb_s = '0;
    for (int k = 0; k < 4; k++) begin
      a_or_s = a_or_s | a_pad_s[k*W +: W];
    end
    for (int j = 0; j < W; j++) begin
      if (a_or_s[j]) begin
        a_msb_s = CW'(j);
      end else begin
        a_msb_s = a_msb_s;
      end
    end
  end

  // Final RUN index captured together with the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      last_idx_q <= a_msb_s;
    end else begin
      last_idx_q <= last_idx_q;
    end
  end

  // RUN ends after the cycle that processes the captured index.
  always_comb begin
    last_s = (cnt_q == last_idx_q);
  end
`else
  // RUN always covers every bit index of a limb.
  always_comb begin
    last_s = (cnt_q == CW'(W - 1));
  end
`endif

  // Place each diagonal accumulator at its limb offset and fold; bits above 2N are dropped.
  always_comb begin
    comb_s = '0;
    for (int s = 0; s < 7; s++) begin
      for (int j = 0; j < AW; j++) begin
        if ((s * W + j) < (2 * N)) begin
          comb_s[s*W+j] = comb_s[s*W+j] ^ acc_q[s][j];
        end else begin
          comb_s = comb_s;
        end
      end
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/COMBINE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    done_d  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      al_d[k] = al_q[k];
      bl_d[k] = bl_q[k];
    end
    for (int s = 0; s < 7; s++) begin
      acc_d[s] = acc_q[s];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          for (int k = 0; k < 4; k++) begin
            al_d[k] = a_pad_s[k*W +: W];
            bl_d[k] = {{W{1'b0}}, b_pad_s[k*W +: W]};
          end
          for (int s = 0; s < 7; s++) begin
            acc_d[s] = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // al holds bit i of each a-limb in its LSB; bl holds each b-limb already shifted by i.
        for (int p = 0; p < 4; p++) begin
          if (al_q[p][0]) begin
            for (int q = 0; q < 4; q++) begin
              acc_d[p+q] = acc_d[p+q] ^ bl_q[q];
            end
          end else begin
            acc_d[p] = acc_d[p];
          end
        end
        for (int k = 0; k < 4; k++) begin
          al_d[k] = al_q[k] >> 1;
          bl_d[k] = bl_q[k] << 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (last_s) begin
          state_d = COMBINE;
        end else begin
          state_d = RUN;
        end
      end
      COMBINE: begin
        c_d     = comb_s;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      for (int k = 0; k < 4; k++) begin
        al_q[k] <= '0;
        bl_q[k] <= '0;
      end
      for (int s = 0; s < 7; s++) begin
        acc_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      for (int k = 0; k < 4; k++) begin
        al_q[k] <= al_d[k];
        bl_q[k] <= bl_d[k];
      end
      for (int s = 0; s < 7; s++) begin
        acc_q[s] <= acc_d[s];
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_toom4_serial_clmul.sv
// Bench for toom4_serial_clmul: N=409 and N=8 instances checked every cycle against a
// spec-level timing/product model, plus directed vectors with literal expectations.
module tb_toom4_serial_clmul;

`ifdef TOOM4_CLMUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start409, start8;
  logic [408:0] a409, b409;
  logic [7:0]   a8, b8;
  logic         busy409, done409, busy8, done8;
  logic [817:0] c409;
  logic [15:0]  c8;

  int nvec;
  int nerr;
  bit chk_en;

  toom4_serial_clmul #(.N(409)) dut409 (
    .clk(clk), .rst(rst), .start(start409), .a(a409), .b(b409),
    .busy(busy409), .done(done409), .c(c409)
  );

  toom4_serial_clmul #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .c(c8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product by shift-and-xor over the full operand.
  function automatic logic [817:0] clmul(input logic [408:0] x, input logic [408:0] y);
    logic [817:0] r;
    r = '0;
    for (int i = 0; i < 409; i++) begin
      if (x[i]) r = r ^ ({409'd0, y} << i);
    end
    return r;
  endfunction

  // Edges from start acceptance to the done edge.
  function automatic int lat_of(input logic [408:0] x, input int n, input int w);
    int m;
    m = 0;
    for (int k = 0; k < n; k++) begin
      if (x[k] && ((k % w) > m)) m = k % w;
    end
    return ET ? (m + 2) : (w + 1);
  endfunction

  task automatic chk(input string nm, input logic [817:0] act, input logic [817:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Spec-level model, 409-bit instance.
  logic m_busy409, m_done409;
  int   m_cnt409;
  logic [817:0] m_exp409, m_c409;
  always @(posedge clk) begin
    if (rst) begin
      m_busy409 <= 1'b0; m_done409 <= 1'b0; m_cnt409 <= 0; m_c409 <= '0; m_exp409 <= '0;
    end else begin
      m_done409 <= 1'b0;
      if (!m_busy409) begin
        if (start409) begin
          m_busy409 <= 1'b1;
          m_cnt409  <= lat_of(a409, 409, 103) - 1;
          m_exp409  <= clmul(a409, b409);
        end
      end else if (m_cnt409 == 0) begin
        m_busy409 <= 1'b0; m_done409 <= 1'b1; m_c409 <= m_exp409;
      end else begin
        m_cnt409 <= m_cnt409 - 1;
      end
    end
  end

  // Spec-level model, 8-bit instance.
  logic m_busy8, m_done8;
  int   m_cnt8;
  logic [15:0] m_exp8, m_c8;
  logic [817:0] p8;
  always @(posedge clk) begin
    if (rst) begin
      m_busy8 <= 1'b0; m_done8 <= 1'b0; m_cnt8 <= 0; m_c8 <= '0; m_exp8 <= '0;
    end else begin
      m_done8 <= 1'b0;
      if (!m_busy8) begin
        if (start8) begin
          p8 = clmul({401'd0, a8}, {401'd0, b8});
          m_busy8 <= 1'b1;
          m_cnt8  <= lat_of({401'd0, a8}, 8, 2) - 1;
          m_exp8  <= p8[15:0];
        end
      end else if (m_cnt8 == 0) begin
        m_busy8 <= 1'b0; m_done8 <= 1'b1; m_c8 <= m_exp8;
      end else begin
        m_cnt8 <= m_cnt8 - 1;
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy409", {817'd0, busy409}, {817'd0, m_busy409});
      chk("done409", {817'd0, done409}, {817'd0, m_done409});
      chk("c409", c409, m_c409);
      chk("busy8", {817'd0, busy8}, {817'd0, m_busy8});
      chk("done8", {817'd0, done8}, {817'd0, m_done8});
      chk("c8", {802'd0, c8}, {802'd0, m_c8});
    end
  end

  task automatic op409(input string nm, input logic [408:0] x, input logic [408:0] y,
                       input logic [817:0] exp_c, input int exp_lat, input bit imm);
    int k;
    if (!imm) @(posedge clk);
    #1;
    a409 = x; b409 = y; start409 = 1'b1;
    @(posedge clk); #1;
    start409 = 1'b0;
    a409 = ~x; b409 = ~y;
    k = 0;
    while (!done409 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_lat"}, 818'(k), 818'(exp_lat));
    chk({nm, "_c"}, c409, exp_c);
  endtask

  task automatic op8(input string nm, input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] exp_c, input int exp_lat);
    int k;
    @(posedge clk); #1;
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_lat"}, 818'(k), 818'(exp_lat));
    chk({nm, "_c"}, {802'd0, c8}, {802'd0, exp_c});
  endtask

  logic [817:0] one_c, big_c;
  logic [408:0] ones_a, top_a, ra, rb;
  logic [415:0] wide_r;
  logic [817:0] pin;
  int dn, k;

  initial begin
    nvec = 0; nerr = 0; chk_en = 1'b0;
    rst = 1'b1; start409 = 1'b0; start8 = 1'b0;
    a409 = '0; b409 = '0; a8 = '0; b8 = '0;
    one_c  = 818'd1;
    big_c  = one_c << 816;
    ones_a = '1;
    top_a  = 409'd1 << 408;

    // Model pinned against hand-computed products.
    pin = clmul(409'h3, 409'h3);        chk("pin_3x3", pin, 818'h5);
    pin = clmul(409'hFF, 409'hFF);      chk("pin_ffxff", pin, 818'h5555);
    pin = clmul(409'h5, 409'h3);        chk("pin_5x3", pin, 818'hF);
    pin = clmul(top_a, top_a);          chk("pin_top", pin, big_c);

    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_busy", {817'd0, busy409}, 818'd0);
    chk("rst_done", {817'd0, done409}, 818'd0);
    chk("rst_c", c409, 818'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    op409("one", 409'd1, 409'd1, 818'd1, ET ? 2 : 104, 1'b0);
    op409("top", top_a, top_a, big_c, ET ? 101 : 104, 1'b0);
    op409("ones", ones_a, 409'd1, {409'd0, ones_a}, 104, 1'b0);
    op409("b2b", 409'h5, 409'h3, 818'hF, ET ? 4 : 104, 1'b1);
    op409("zero", 409'd0, ones_a, 818'd0, ET ? 2 : 104, 1'b0);
    op8("n8_3x3", 8'h03, 8'h03, 16'h0005, 3);
    op8("n8_ffxff", 8'hFF, 8'hFF, 16'h5555, 3);

    // Second start mid-RUN must be ignored.
    @(posedge clk); #1;
    a409 = ones_a; b409 = 409'h3; start409 = 1'b1;
    @(posedge clk); #1;
    start409 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    a409 = top_a; b409 = top_a; start409 = 1'b1;
    @(posedge clk); #1;
    start409 = 1'b0;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      if (done409) begin
        dn++;
        chk("midstart_c", c409, clmul(ones_a, 409'h3));
      end
      @(posedge clk); #1;
    end
    chk("midstart_pulses", 818'(dn), 818'd1);

    // Reset in the middle of RUN aborts without done.
    @(posedge clk); #1;
    a409 = 409'h1234_5678_9ABC; b409 = ones_a; start409 = 1'b1;
    @(posedge clk); #1;
    start409 = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 150; i++) begin
      if (done409) dn++;
      @(posedge clk); #1;
    end
    chk("abort_pulses", 818'(dn), 818'd0);
    chk("abort_c", c409, 818'd0);
    chk("abort_busy", {817'd0, busy409}, 818'd0);
    op409("after_rst", 409'h1234_5678_9ABC, ones_a, clmul(409'h1234_5678_9ABC, ones_a),
          lat_of(409'h1234_5678_9ABC, 409, 103), 1'b0);

    // Random operands, some shortened to vary the top set bit.
    for (int n = 0; n < 120; n++) begin
      for (int w = 0; w < 13; w++) wide_r[w*32 +: 32] = $urandom;
      ra = wide_r[408:0];
      for (int w = 0; w < 13; w++) wide_r[w*32 +: 32] = $urandom;
      rb = wide_r[408:0];
      if (n % 3 == 1) ra = ra >> $urandom_range(0, 408);
      if (n % 5 == 2) rb = rb >> $urandom_range(0, 408);
      op409("rnd409", ra, rb, clmul(ra, rb), lat_of(ra, 409, 103), 1'b0);
    end
    for (int n = 0; n < 400; n++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      pin = clmul({401'd0, a8}, {401'd0, b8});
      op8("rnd8", a8, b8, pin[15:0], lat_of({401'd0, a8}, 8, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
